detector_jogada: RTL and testbench

- Upstream input stage for the memory-game datapath/control unit.
- Converts the raw `botoes` from the board into a clean one-cycle `jogada` pulse plus a registered one-hot `jogada_valor`. These drive the game's `chaves` comparison and its play-strobe input.
- Internal stages: 2-FF synchroniser, per-press debounce filter, one-hot validation, and a release wait so that one press gives exactly one play.

---
 rtl/detector_jogada_pkg.sv | 26 ++
 rtl/detector_jogada_if.sv | 40 ++++
 rtl/detector_jogada_sincronizador_2ff.sv | 33 +++
 rtl/detector_jogada.sv | 163 ++++++++++++++++
 tb/tb_detector_jogada.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Shared definitions for the button play detector of the memory game:
//   ESTADO_W / BOTOES_W : widths of the state code and of the button vector
//   estado_t            : FSM state codes (also shown on the hex display)
//   eh_one_hot()        : true when exactly one bit of a button vector is set
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

    localparam int ESTADO_W = 4;
    localparam int BOTOES_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        ESPERA_SOLTA  = 4'd1,
        ESPERA_APERTO = 4'd2,
        FILTRA        = 4'd3,
        REGISTRA      = 4'd4,
        ESPERA_LIBERA = 4'd5
    } estado_t;

    // v & (v-1) clears the lowest set bit; zero afterwards means a single bit.
    function automatic logic eh_one_hot(input logic [BOTOES_W-1:0] v);
        return (v != '0) && ((v & (v - BOTOES_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// -----------------------------------------------------------------------------
// detector_jogada_if
// Signal bundle between the board/game control unit and the play detector.
//   habilita     : control unit -> detector, enables play detection
//   botoes       : board -> detector, raw asynchronous button levels
//   jogada       : detector -> game, one-cycle strobe of an accepted play
//   jogada_valor : detector -> game, last accepted one-hot value
//   invalida     : detector -> game, one-cycle strobe of a non one-hot press
//   timeout      : detector -> game, one-cycle strobe of an idle timeout
//   db_estado    : detector -> display, FSM state code
//   db_botoes    : detector -> display, synchronised button value
//
// Handshake: there is no ready/backpressure. jogada, invalida and timeout are
// single-cycle strobes that the consumer must sample on the clock edge that
// follows their assertion; jogada_valor is valid from the cycle jogada is high
// and stays stable until the next accepted play.
// -----------------------------------------------------------------------------
interface detector_jogada_if;
    import detector_jogada_pkg::*;

    logic                habilita;
    logic [BOTOES_W-1:0] botoes;
    logic                jogada;
    logic [BOTOES_W-1:0] jogada_valor;
    logic                invalida;
    logic                timeout;
    logic [ESTADO_W-1:0] db_estado;
    logic [BOTOES_W-1:0] db_botoes;

    modport master (
        output habilita, botoes,
        input  jogada, jogada_valor, invalida, timeout, db_estado, db_botoes
    );

    modport slave (
        input  habilita, botoes,
        output jogada, jogada_valor, invalida, timeout, db_estado, db_botoes
    );

endinterface

// File: rtl/detector_jogada_sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Double flip-flop synchroniser for asynchronous level inputs.
//   i_clock   : destination clock, rising edge
//   i_reset_n : asynchronous active-low reset, clears both stages to 0
//   i_d       : asynchronous input vector (W bits)
//   o_q       : i_d delayed by two clocks
// -----------------------------------------------------------------------------
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Turns the raw board buttons into one clean play per physical press:
// synchroniser -> debounce filter -> one-hot validation -> release wait.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press or a release (>=2)
//   TIMEOUT_CYCLES  : idle cycles in ESPERA_APERTO before a timeout strobe
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : detector_jogada_if.slave (habilita, botoes in; jogada,
//           jogada_valor, invalida, timeout, db_estado, db_botoes out)
//
// Build option: define DETECTOR_JOGADA_TIMEOUT_EN to enable the idle timeout
// counter; without it the timeout output is tied to 0.
// -----------------------------------------------------------------------------
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic               clock,
    input  logic               reset,
    detector_jogada_if.slave   bus
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ?
                             DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [BOTOES_W-1:0] w_sync;
    estado_t             r_estado;
    logic [CNT_W-1:0]    r_cnt;
    logic [BOTOES_W-1:0] r_candidato;
    logic [BOTOES_W-1:0] r_jogada_valor;
    logic                r_jogada;
    logic                r_invalida;

    sincronizador_2ff #(
        .W (BOTOES_W)
    ) u_sync (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_d       (bus.botoes),
        .o_q       (w_sync)
    );

    // The play/invalid strobes are issued on the edge that enters REGISTRA,
    // so they are high exactly while the FSM sits in REGISTRA.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= ESPERA_SOLTA;
            r_cnt          <= '0;
            r_candidato    <= '0;
            r_jogada_valor <= '0;
            r_jogada       <= 1'b0;
            r_invalida     <= 1'b0;
        end else begin
            r_jogada   <= 1'b0;
            r_invalida <= 1'b0;
            if (!bus.habilita && r_estado != REGISTRA) begin
                r_estado <= ESPERA_SOLTA;
                r_cnt    <= '0;
            end else begin
                case (r_estado)
                    ESPERA_SOLTA, ESPERA_LIBERA: begin
                        // Both wait for a debounced all-released vector.
                        if (w_sync != '0) begin
                            r_cnt <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_estado <= ESPERA_APERTO;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= inc_sat(r_cnt);
                        end
                    end
                    ESPERA_APERTO: begin
                        if (w_sync != '0) begin
                            r_estado    <= FILTRA;
                            r_candidato <= w_sync;
                            r_cnt       <= '0;
                        end
                    end
                    FILTRA: begin
                        if (w_sync == '0) begin
                            r_estado <= ESPERA_APERTO;
                            r_cnt    <= '0;
                        end else if (w_sync != r_candidato) begin
                            // Value changed while still pressed: restart filter.
                            r_candidato <= w_sync;
                            r_cnt       <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_estado <= REGISTRA;
                            r_cnt    <= '0;
                            if (eh_one_hot(r_candidato)) begin
                                r_jogada       <= 1'b1;
                                r_jogada_valor <= r_candidato;
                            end else begin
                                r_invalida <= 1'b1;
                            end
                        end else begin
                            r_cnt <= inc_sat(r_cnt);
                        end
                    end
                    REGISTRA: begin
                        r_estado <= ESPERA_LIBERA;
                        r_cnt    <= '0;
                    end
                    default: begin
                        r_estado <= ESPERA_SOLTA;
                        r_cnt    <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt_ocioso;
    logic             r_timeout;

    // Counts only while the FSM will stay in ESPERA_APERTO, so a press that
    // moves to FILTRA can never coincide with a timeout strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_ocioso <= '0;
            r_timeout    <= 1'b0;
        end else if (r_estado == ESPERA_APERTO && bus.habilita && w_sync == '0) begin
            if (r_cnt_ocioso == TO_LAST) begin
                r_cnt_ocioso <= '0;
                r_timeout    <= 1'b1;
            end else begin
                r_cnt_ocioso <= inc_sat(r_cnt_ocioso);
                r_timeout    <= 1'b0;
            end
        end else begin
            r_cnt_ocioso <= '0;
            r_timeout    <= 1'b0;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.jogada       = r_jogada;
    assign bus.jogada_valor = r_jogada_valor;
    assign bus.invalida     = r_invalida;
    assign bus.db_estado    = r_estado;
    assign bus.db_botoes    = w_sync;

endmodule

// File: tb/tb_detector_jogada.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada
// Directed bench for detector_jogada with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20
// and a 20 ns clock. Inputs change 1 ns after a rising edge; outputs are read
// at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_detector_jogada;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_q[$];

    detector_jogada_if bus ();

    detector_jogada #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #10 clock = ~clock;

    // ---------------- scoreboard ----------------
    // Every jogada pulse must match the next expected value queued by a test.
    always @(negedge clock) begin
        logic [3:0] exp_v;
        if (reset === 1'b1 && (bus.jogada === 1'b1 || bus.invalida === 1'b1)) begin
            checks++;
            if (bus.jogada === 1'b1 && bus.invalida === 1'b1) begin
                errors++;
                $display("FAIL excl: jogada=1 invalida=1, required not both high");
            end
        end
        if (reset === 1'b1 && bus.jogada === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: jogada pulse valor=%b, required no pulse", bus.jogada_valor);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.jogada_valor !== exp_v) begin
                    errors++;
                    $display("FAIL sb_valor: got %b required %b", bus.jogada_valor, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset       = 1'b0;
        bus.habilita = 1'b1;
        bus.botoes   = 4'b0000;
        step();
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL rst_estado: got %0d required 1", bus.db_estado); end
        checks++; if (bus.jogada !== 1'b0 || bus.invalida !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: jogada=%b invalida=%b timeout=%b required 0", bus.jogada, bus.invalida, bus.timeout); end
        checks++; if (bus.jogada_valor !== 4'b0000) begin errors++; $display("FAIL rst_valor: got %b required 0000", bus.jogada_valor); end
        checks++; if (bus.db_botoes !== 4'b0000) begin errors++; $display("FAIL rst_db_botoes: got %b required 0000", bus.db_botoes); end
        reset = 1'b1;
        steps(3);
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL rst_solta3: got %0d required 1", bus.db_estado); end
        step();
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL rst_aperto4: got %0d required 2", bus.db_estado); end
        steps(2);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL rst_aperto6: got %0d required 2", bus.db_estado); end
    endtask

    task automatic test_press_clean();
        int n = 0;
        int pos = 0;
        exp_q.push_back(4'b0100);
        bus.botoes = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.jogada === 1'b1) begin n++; pos = i; end
        end
        checks++; if (n != 1) begin errors++; $display("FAIL clean_count: got %0d pulses required 1", n); end
        checks++; if (pos != 7) begin errors++; $display("FAIL clean_latency: pulse after edge %0d required 7", pos); end
        checks++; if (bus.jogada_valor !== 4'b0100) begin errors++; $display("FAIL clean_valor: got %b required 0100", bus.jogada_valor); end
        checks++; if (bus.db_estado !== 4'd5) begin errors++; $display("FAIL clean_libera: got %0d required 5", bus.db_estado); end
        checks++; if (bus.db_botoes !== 4'b0100) begin errors++; $display("FAIL clean_db_botoes: got %b required 0100", bus.db_botoes); end
    endtask

    task automatic test_bounce();
        int n_toggle = 0;
        int n_stable = 0;
        bus.botoes = 4'b0000;
        steps(8);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL bounce_idle: got %0d required 2", bus.db_estado); end
        for (int i = 0; i < 6; i++) begin
            bus.botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
            if (bus.jogada === 1'b1) n_toggle++;
        end
        exp_q.push_back(4'b0010);
        bus.botoes = 4'b0010;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.jogada === 1'b1) n_stable++;
        end
        checks++; if (n_toggle != 0) begin errors++; $display("FAIL bounce_toggle: got %0d pulses required 0", n_toggle); end
        checks++; if (n_stable != 1) begin errors++; $display("FAIL bounce_count: got %0d pulses required 1", n_stable); end
        checks++; if (bus.jogada_valor !== 4'b0010) begin errors++; $display("FAIL bounce_valor: got %b required 0010", bus.jogada_valor); end
    endtask

    task automatic test_invalid();
        int n_inv = 0;
        int n_jog = 0;
        bus.botoes = 4'b0000;
        steps(8);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL inv_idle: got %0d required 2", bus.db_estado); end
        bus.botoes = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.invalida === 1'b1) n_inv++;
            if (bus.jogada === 1'b1) n_jog++;
        end
        checks++; if (n_inv != 1) begin errors++; $display("FAIL inv_count: got %0d invalida pulses required 1", n_inv); end
        checks++; if (n_jog != 0) begin errors++; $display("FAIL inv_jogada: got %0d jogada pulses required 0", n_jog); end
        checks++; if (bus.jogada_valor !== 4'b0010) begin errors++; $display("FAIL inv_valor: got %b required 0010", bus.jogada_valor); end
        // Changing to a valid value while still holding must be ignored.
        bus.botoes = 4'b0001;
        n_jog = 0;
        for (int i = 0; i < 10; i++) begin step(); if (bus.jogada === 1'b1) n_jog++; end
        // Release shorter than the debounce window is also not enough.
        bus.botoes = 4'b0000;
        steps(3);
        bus.botoes = 4'b0001;
        for (int i = 0; i < 12; i++) begin step(); if (bus.jogada === 1'b1) n_jog++; end
        checks++; if (n_jog != 0) begin errors++; $display("FAIL inv_held: got %0d pulses required 0", n_jog); end
        checks++; if (bus.db_estado !== 4'd5) begin errors++; $display("FAIL inv_libera: got %0d required 5", bus.db_estado); end
        // A full four-cycle release re-arms the detector.
        bus.botoes = 4'b0000;
        steps(4);
        exp_q.push_back(4'b0001);
        bus.botoes = 4'b0001;
        for (int i = 0; i < 12; i++) begin step(); if (bus.jogada === 1'b1) n_jog++; end
        checks++; if (n_jog != 1) begin errors++; $display("FAIL inv_rearm: got %0d pulses required 1", n_jog); end
        checks++; if (bus.jogada_valor !== 4'b0001) begin errors++; $display("FAIL inv_rearm_valor: got %b required 0001", bus.jogada_valor); end
    endtask

    task automatic test_abort();
        int n = 0;
        bus.botoes = 4'b0000;
        steps(8);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL abort_idle: got %0d required 2", bus.db_estado); end
        bus.botoes = 4'b1000;
        steps(4);
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL abort_filtra: got %0d required 3", bus.db_estado); end
        bus.habilita = 1'b0;
        step();
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL abort_solta: got %0d required 1", bus.db_estado); end
        for (int i = 0; i < 8; i++) begin step(); if (bus.jogada === 1'b1 || bus.invalida === 1'b1) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL abort_pulse: got %0d pulses required 0", n); end
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL abort_hold: got %0d required 1", bus.db_estado); end
        bus.habilita = 1'b1;
        bus.botoes   = 4'b0000;
        steps(8);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL abort_recover: got %0d required 2", bus.db_estado); end
    endtask

    task automatic test_reset_mid_press();
        int n = 0;
        bus.botoes = 4'b1000;
        steps(4);
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL rmid_filtra: got %0d required 3", bus.db_estado); end
        reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL rmid_async: got %0d required 1", bus.db_estado); end
        checks++; if (bus.jogada_valor !== 4'b0000) begin errors++; $display("FAIL rmid_valor: got %b required 0000", bus.jogada_valor); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin step(); if (bus.jogada === 1'b1) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL rmid_held: got %0d pulses required 0", n); end
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL rmid_solta: got %0d required 1", bus.db_estado); end
        bus.botoes = 4'b0000;
        steps(8);
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL rmid_idle: got %0d required 2", bus.db_estado); end
        exp_q.push_back(4'b1000);
        bus.botoes = 4'b1000;
        for (int i = 0; i < 10; i++) begin step(); if (bus.jogada === 1'b1) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL rmid_repress: got %0d pulses required 1", n); end
        checks++; if (bus.jogada_valor !== 4'b1000) begin errors++; $display("FAIL rmid_valor2: got %b required 1000", bus.jogada_valor); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int p1 = 0;
        int p2 = 0;
        int guard = 0;
        bus.botoes = 4'b0000;
        // Poll for entry into ESPERA_APERTO; that edge is idle cycle 0.
        while (bus.db_estado !== 4'd2 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (bus.db_estado !== 4'd2) begin
            errors++;
            $display("FAIL to_entry: got %0d required 2 within 20 cycles", bus.db_estado);
        end else begin
            for (int i = 1; i <= 45; i++) begin
                step();
                if (bus.timeout === 1'b1) begin
                    n++;
                    if (n == 1) p1 = i;
                    if (n == 2) p2 = i;
                end
            end
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
            checks++; if (n != 2) begin errors++; $display("FAIL to_count: got %0d pulses required 2", n); end
            checks++; if (p1 != 20 || p2 != 40) begin errors++; $display("FAIL to_position: got %0d,%0d required 20,40", p1, p2); end
            checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL to_state: got %0d required 2", bus.db_estado); end
`else
            checks++; if (n != 0) begin errors++; $display("FAIL to_disabled: got %0d pulses required 0", n); end
`endif
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_press_clean();
        test_bounce();
        test_invalid();
        test_abort();
        test_reset_mid_press();
        test_timeout();
        steps(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: %0d expected plays never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
